// File: rtl/chacha_pkg.sv
// Shared ChaCha20 block types and byte-packing helpers used by the block
// serialiser and deserialiser.
package chacha_pkg;

    localparam int BLOCK_BYTES   = 64;
    localparam int WORDS_PER_ROW = 4;
    localparam int BLOCK_BITS    = BLOCK_BYTES * 8;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] block_t;

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } asm_state_t;

    function automatic block_t fill_block(input logic [7:0] value);
        return block_t'({BLOCK_BYTES{value}});
    endfunction

    // Packed layout already puts [0][0] at the bottom, so byte n of the
    // RFC 8439 little-endian stream sits at flat bits [8n +: 8].
    function automatic block_t put_byte(input block_t blk, input logic [5:0] idx,
                                        input logic [7:0] value);
        logic [BLOCK_BITS-1:0] flat;
        flat = blk;
        flat[{idx, 3'b000} +: 8] = value;
        return block_t'(flat);
    endfunction

endpackage

// File: rtl/chacha_block_slot.sv
// Single-entry output holding register with valid/ready; reports to the
// producer whether it can accept a new block on the coming edge.
module chacha_block_slot (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  chacha_pkg::block_t load_block,
    input  logic [6:0]         load_len,
    input  logic               load_last,
    input  logic               out_ready,
    output chacha_pkg::block_t out_block,
    output logic               out_valid,
    output logic [6:0]         out_len,
    output logic               out_last,
    output logic               free
);

    assign free = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_block <= '0;
            out_len   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_block <= load_block;
            out_len   <= load_len;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/chacha_block_deserialiser.sv
// Packs a valid/ready byte stream into 64-byte ChaCha20 blocks, closing early
// on in_last and holding a finished block while the output slot is busy.
module chacha_block_deserialiser #(
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter int         BLOCK_BYTES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output chacha_pkg::block_t out_block,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         out_len,
    output logic               out_last
);

    import chacha_pkg::*;

    asm_state_t state_q, state_d;
    logic [5:0] cnt_q;
    block_t     asm_q;
    block_t     asm_wr;
    logic [6:0] pend_len_q;
    logic       pend_last_q;

    logic       accept;
    logic       close;
    logic       slot_free;
    logic       load;
    block_t     load_block;
    logic [6:0] load_len;
    logic       load_last;

    assign accept = in_valid && in_ready;
    assign close  = accept && ((cnt_q == 6'(BLOCK_BYTES - 1)) || in_last);
    assign asm_wr = put_byte(asm_q, cnt_q, in_byte);

    always_ff @(posedge clk) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    // NOTE: every signal driven from always_comb gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (close && !slot_free) state_d = PENDING;
            PENDING: if (slot_free)           state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // A closing byte is merged on the fly so it reaches the slot on its own edge.
    always_comb begin
        in_ready   = 1'b0;
        load       = 1'b0;
        load_block = asm_wr;
        load_len   = {1'b0, cnt_q} + 7'd1;
        load_last  = in_last;
        unique case (state_q)
            COLLECT: begin
                in_ready = !rst;
                load     = close && slot_free;
            end
            PENDING: begin
                load       = slot_free;
                load_block = asm_q;
                load_len   = pend_len_q;
                load_last  = pend_last_q;
            end
            default: ;
        endcase
    end

    // NOTE: the assembly register is reset to PAD rather than left unknown,
    // because unwritten lanes of a short block are visible at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            asm_q       <= fill_block(PAD_BYTE);
            pend_len_q  <= '0;
            pend_last_q <= 1'b0;
        end else begin
            if (accept) cnt_q <= close ? 6'd0 : cnt_q + 6'd1;

            if (load)        asm_q <= fill_block(PAD_BYTE);
            else if (accept) asm_q <= asm_wr;

            if (close) begin
                pend_len_q  <= {1'b0, cnt_q} + 7'd1;
                pend_last_q <= in_last;
            end
        end
    end

    chacha_block_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_block(load_block),
        .load_len  (load_len),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_valid (out_valid),
        .out_len   (out_len),
        .out_last  (out_last),
        .free      (slot_free)
    );

endmodule

// File: tb/tb_chacha_block_deserialiser.sv
// Scoreboard bench for chacha_block_deserialiser: a byte-level model predicts
// each block, a negedge monitor compares handshaked blocks and stall stability.
module tb_chacha_block_deserialiser;

    import chacha_pkg::*;

    typedef struct {
        block_t     blk;
        logic [6:0] len;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    block_t     out_block;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [6:0] out_len;
    logic       out_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cycles = 0;

    exp_t sb[$];
    int   hs_cyc[$];
    logic [7:0] mb[64];
    int   mcnt = 0;

    logic       prev_stall = 1'b0;
    block_t     held_blk;
    logic [6:0] held_len;
    logic       held_last;

    chacha_block_deserialiser dut (
        .clk      (clk),
        .rst      (rst),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_block(out_block),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_len  (out_len),
        .out_last (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mb[i] = 8'h00;
        mcnt = 0;
    endtask

    task automatic model_accept(input logic [7:0] b, input logic last);
        exp_t e;
        mb[mcnt] = b;
        if (mcnt == 63 || last) begin
            for (int w = 0; w < 16; w++)
                e.blk[w / 4][w % 4] = {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
            e.len  = 7'(mcnt + 1);
            e.last = last;
            sb.push_back(e);
            model_reset();
        end else begin
            mcnt++;
        end
    endtask

    // Monitor: compare every handshaked block and check stability under stall.
    always @(negedge clk) begin
        if (!rst && prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_block !== held_blk || out_len !== held_len
                || out_last !== held_last) begin
                errors++;
                $display("FAIL stall_stability: valid=%0b len=%0d last=%0b, held len=%0d last=%0b",
                         out_valid, out_len, out_last, held_len, held_last);
            end
        end
        prev_stall = out_valid && !out_ready;
        held_blk   = out_block;
        held_len   = out_len;
        held_last  = out_last;

        if (!rst && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_block: got len=%0d last=%0b, expected no block",
                         out_len, out_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_block !== e.blk) begin
                    errors++;
                    $display("FAIL block_data: got %h, expected %h", out_block, e.blk);
                end
                checks++;
                if (out_len !== e.len) begin
                    errors++;
                    $display("FAIL block_len: got %0d, expected %0d", out_len, e.len);
                end
                checks++;
                if (out_last !== e.last) begin
                    errors++;
                    $display("FAIL block_last: got %0b, expected %0b", out_last, e.last);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic last);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            waited++;
            stall_cycles++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, waited);
        end else begin
            @(posedge clk);
            model_accept(b, last);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %0b, expected 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_high: got %0b, expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_len !== 7'd0 || out_last !== 1'b0 || out_block !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b len=%0d last=%0b, expected all 0",
                     out_valid, out_len, out_last);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_block();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
        in_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_latency: out_valid=%0b one cycle after last byte, expected 1", out_valid);
        end
        checks++;
        if (out_block[0][0] !== 32'h03020100 || out_block[1][2] !== 32'h1B1A1918
            || out_block[3][3] !== 32'h3F3E3D3C) begin
            errors++;
            $display("FAIL full_words: [0][0]=%h [1][2]=%h [3][3]=%h, expected 03020100 1b1a1918 3f3e3d3c",
                     out_block[0][0], out_block[1][2], out_block[3][3]);
        end
        checks++;
        if (out_len !== 7'd64 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL full_len_last: len=%0d last=%0b, expected 64 0", out_len, out_last);
        end
        idle(3);
    endtask

    task automatic test_short_block();
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 4);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_block[0][0] !== 32'hA3A2A1A0 || out_block[0][1] !== 32'h000000A4
            || out_block[2][3] !== 32'h0) begin
            errors++;
            $display("FAIL short_words: valid=%0b [0][0]=%h [0][1]=%h [2][3]=%h, expected 1 a3a2a1a0 000000a4 0",
                     out_valid, out_block[0][0], out_block[0][1], out_block[2][3]);
        end
        checks++;
        if (out_len !== 7'd5 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL short_len_last: len=%0d last=%0b, expected 5 1", out_len, out_last);
        end
        idle(3);
        // A stray in_last without in_valid must not close anything.
        in_last = 1'b1;
        idle(3);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 128; i++) send(8'(i), 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_block[0][0] !== 32'h03020100) begin
            errors++;
            $display("FAIL pending_state: in_ready=%0b valid=%0b [0][0]=%h, expected 0 1 03020100",
                     in_ready, out_valid, out_block[0][0]);
        end
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_block[0][0] !== 32'h43424140) begin
            errors++;
            $display("FAIL pending_release: in_ready=%0b valid=%0b [0][0]=%h, expected 1 1 43424140",
                     in_ready, out_valid, out_block[0][0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        stall_cycles = 0;
        hs_cyc.delete();
        for (int i = 0; i < 192; i++) send(8'(i * 7 + 3), 1'b0);
        idle(3);
        checks++;
        if (stall_cycles !== 0) begin
            errors++;
            $display("FAIL b2b_in_ready: stalled %0d cycles, expected 0", stall_cycles);
        end
        checks++;
        if (hs_cyc.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d blocks, expected 3", hs_cyc.size());
        end else begin
            checks++;
            if (hs_cyc[1] - hs_cyc[0] !== 64 || hs_cyc[2] - hs_cyc[1] !== 64) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d and %0d cycles, expected 64 and 64",
                         hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
            end
        end
    endtask

    task automatic test_reset_mid_block();
        for (int i = 0; i < 20; i++) send(8'hC0 + 8'(i), 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(3);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: out_valid=%0b after mid-block reset, expected 0", out_valid);
        end
        test_full_block();
    endtask

    task automatic test_last_on_64th();
        for (int i = 0; i < 64; i++) send(8'(i), i == 63);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_len !== 7'd64 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL last64: valid=%0b len=%0d last=%0b, expected 1 64 1", out_valid, out_len, out_last);
        end
        idle(2);
        send(8'h55, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (out_block[0][0] !== 32'h00000055 || out_len !== 7'd1) begin
            errors++;
            $display("FAIL last64_restart: [0][0]=%h len=%0d, expected 00000055 1", out_block[0][0], out_len);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_short_block();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        test_last_on_64th();
        idle(4);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d blocks never emitted, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
